// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory request/response
// channel plus the valid/ready output toward IF/ID.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch with prefetch FIFO and redirect flush.
// Define FETCH_PERF_EN to add the bubble_cnt output-starvation counter.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  bubble_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  fetch_ent_t  fifo_q [DEPTH];
  fetch_ent_t  fifo_d [DEPTH];

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [SW-1:0] credit_used;
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;
  fetch_ent_t    head;

  assign credit_used = {1'b0, outstanding_q}
                     + {1'b0, fifo_count_q};
  assign fifo_empty  = (fifo_count_q == '0);
  assign fifo_full   = (fifo_count_q == CW'(DEPTH));
  assign head        = fifo_q[rd_ptr_q];

  // No credit for a same-cycle pop keeps the req path off out_ready.
  assign bus.imem_req  = rst
                       && (credit_used < SW'(DEPTH))
                       && !redirect_valid;
  assign bus.imem_addr = fetch_pc_q;

  assign accept = bus.imem_req && bus.imem_gnt;

  assign bus.out_valid = !fifo_empty && !redirect_valid;
  assign bus.out_pc    = fifo_empty ? 32'h0 : head.pc;
  assign bus.out_inst  = fifo_empty ? 32'h0 : head.inst;

  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.imem_rvalid
              && (drop_cnt_q == '0)
              && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_count_d  = fifo_count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_d        = fifo_q;
    outstanding_d = outstanding_q
                  + CW'(accept)
                  - CW'(bus.imem_rvalid);
    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      resp_pc_d    = redirect_pc;
      fifo_count_d = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      // Everything still in flight after this edge is stale.
      drop_cnt_d   = outstanding_d;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (bus.imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: resp_pc_q, inst: bus.imem_rdata};
        resp_pc_d        = resp_pc_q + 32'd4;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_count_q  <= fifo_count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (bus.out_ready && !bus.out_valid) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(bus.imem_rvalid && outstanding_q == '0));
      assert (!(accept && !bus.imem_rvalid
                && outstanding_q == CW'(DEPTH)));
      assert (!(push && fifo_full));
      assert (!(redirect_valid && redirect_pc[1:0] != 2'b00));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect
// flush, mid-burst reset and optional bubble counter.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  fetch_unit_if bus ();

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  bit gnt_en  = 1'b1;
  bit resp_en = 1'b1;
  pend_t pend [$];

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic        g_acc;

  // One cycle: drive memory side, sample DUT, advance to next negedge.
  task automatic step();
    pend_t e;
    if (resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend[0].addr ^ K;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    bus.imem_gnt = gnt_en;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.out_valid;
    s_pc    = bus.out_pc;
    s_inst  = bus.out_inst;
    g_acc   = rst && bus.imem_req && bus.imem_gnt;
    if (g_acc) begin
      e.addr = bus.imem_addr;
      e.due  = cyc + lat;
      pend.push_back(e);
    end
    if (bus.imem_rvalid) void'(pend.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    resp_en = 1'b1;
    pend.delete();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", s_req); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
    total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", s_pc); end
    total++; if (s_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", s_inst); end
  endtask

  task automatic test_stream();
    int first_gnt = -1;
    int first_val = -1;
    int n = 0;
    logic [31:0] exp = 32'h0;
    lat = 1;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (g_acc && first_gnt < 0) first_gnt = cyc - 1;
      if (s_valid) begin
        if (first_val < 0) first_val = cyc - 1;
        total++; if (s_pc !== exp) begin bad++; $display("FAIL stream_pc got=%h exp=%h", s_pc, exp); end
        total++; if (s_inst !== (exp ^ K)) begin bad++; $display("FAIL stream_inst got=%h exp=%h", s_inst, exp ^ K); end
        exp += 4;
        n++;
      end
    end
    total++; if (first_val - first_gnt !== 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_gnt); end
    total++; if (n !== 18) begin bad++; $display("FAIL stream_count got=%0d exp=18", n); end
  endtask

  task automatic test_stall();
    int grants = 0;
    int n = 0;
    logic [31:0] exp = 32'h0;
    lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (g_acc) grants++;
    end
    total++; if (grants !== 4) begin bad++; $display("FAIL stall_grants got=%0d exp=4", grants); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", s_req); end
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", s_valid); end
    total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL stall_hold_pc got=%h exp=0", s_pc); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && n < 5; i++) begin
      step();
      if (s_valid) begin
        total++; if (s_pc !== exp) begin bad++; $display("FAIL stall_rel_pc got=%h exp=%h", s_pc, exp); end
        total++; if (s_inst !== (exp ^ K)) begin bad++; $display("FAIL stall_rel_inst got=%h exp=%h", s_inst, exp ^ K); end
        exp += 4;
        n++;
      end
    end
    total++; if (n !== 5) begin bad++; $display("FAIL stall_rel_count got=%0d exp=5", n); end
  endtask

  task automatic test_redirect_drop();
    int grants = 0;
    int n = 0;
    logic [31:0] exp = 32'h100;
    lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL drop_redir0_req got=%b exp=0", s_req); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (g_acc) grants++;
    end
    total++; if (grants !== 3) begin bad++; $display("FAIL drop_grants got=%0d exp=3", grants); end
    resp_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL drop_redir_req got=%b exp=0", s_req); end
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (s_valid) begin
        total++; if (s_pc !== exp) begin bad++; $display("FAIL drop_pc got=%h exp=%h", s_pc, exp); end
        total++; if (s_inst !== (exp ^ K)) begin bad++; $display("FAIL drop_inst got=%h exp=%h", s_inst, exp ^ K); end
        exp += 4;
        n++;
      end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL drop_count got=%0d exp=3", n); end
  endtask

  task automatic test_redirect_coincident();
    bit done = 1'b0;
    bit redir;
    int n = 0;
    logic [31:0] exp = 32'h0;
    lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && n < 4; i++) begin
      redir = !done && i >= 10
            && pend.size() > 0 && pend[0].due <= cyc;
      redirect_valid = redir;
      redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      if (redir) begin
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL coin_req got=%b exp=0", s_req); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL coin_valid got=%b exp=0", s_valid); end
        done = 1'b1;
        exp = 32'h200;
      end else if (s_valid) begin
        total++; if (s_pc !== exp) begin bad++; $display("FAIL coin_pc got=%h exp=%h", s_pc, exp); end
        total++; if (s_inst !== (exp ^ K)) begin bad++; $display("FAIL coin_inst got=%h exp=%h", s_inst, exp ^ K); end
        exp += 4;
        if (done) n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL coin_count got=%0d exp=4", n); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [31:0] exp = 32'h0;
    lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && n < 3; i++) begin
      redirect_valid = (i == 8) || (i == 9);
      redirect_pc = (i == 8) ? 32'h300 : 32'h400;
      step();
      redirect_valid = 1'b0;
      if (i == 8 || i == 9) begin
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b exp=0", s_valid); end
        exp = 32'h400;
      end else if (s_valid) begin
        total++; if (s_pc !== exp) begin bad++; $display("FAIL b2b_pc got=%h exp=%h", s_pc, exp); end
        total++; if (s_inst !== (exp ^ K)) begin bad++; $display("FAIL b2b_inst got=%h exp=%h", s_inst, exp ^ K); end
        exp += 4;
        if (i > 9) n++;
      end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", n); end
  endtask

  task automatic test_reset_mid();
    bit got_gnt = 1'b0;
    bit got_val = 1'b0;
    lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL mid_full_valid got=%b exp=1", s_valid); end
    rst = 1'b0;
    pend.delete();
    step();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%b exp=0", s_req); end
    step();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL mid_after_valid got=%b exp=0", s_valid); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL mid_after_req got=%b exp=0", s_req); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && !got_val; i++) begin
      step();
      if (g_acc && !got_gnt) begin
        got_gnt = 1'b1;
        total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL mid_restart_addr got=%h exp=0", s_addr); end
      end
      if (s_valid) begin
        got_val = 1'b1;
        total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL mid_restart_pc got=%h exp=0", s_pc); end
        total++; if (s_inst !== K) begin bad++; $display("FAIL mid_restart_inst got=%h exp=%h", s_inst, K); end
      end
    end
    total++; if (got_val !== 1'b1) begin bad++; $display("FAIL mid_restart_timeout got=%b exp=1", got_val); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int bubbles = 0;
    lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    total++; if (bubble_cnt !== 32'h0) begin bad++; $display("FAIL perf_reset got=%0d exp=0", bubble_cnt); end
    for (int i = 0; i < 30; i++) begin
      redirect_valid = (i == 8);
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      if (!s_valid) bubbles++;
    end
    total++; if (bubble_cnt !== 32'(bubbles)) begin bad++; $display("FAIL perf_bubbles got=%0d exp=%0d", bubble_cnt, bubbles); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_coincident();
    test_back_to_back();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
